// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, through a single full-subtractor cell with a registered borrow.
// A start/busy/done handshake frames each operation. The result, final
// borrow and signed overflow are held from the done pulse until the first
// RUN cycle of the next accepted operation.

// One-bit full subtractor: difference and borrow-out of x - y - c.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);

    // Pure combinational difference/borrow cell.
    always_comb begin
        d  = x ^ y ^ c;
        bo = (~x & y) | (~x & c) | (y & c);
    end

endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // One extra counter bit so the count never wraps before WIDTH.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             a_msb;
    logic             b_msb;

    logic             d;
    logic             borrow_next;
    logic             last_bit;

    // The single arithmetic cell, fed from the LSBs of the shift registers.
    full_subtractor u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .c  (borrow),
        .d  (d),
        .bo (borrow_next)
    );

    // Flags the cycle in which the MSB pair is being processed.
    always_comb begin
        last_bit = (count == CW'(WIDTH - 1));
    end

    // Sequencer and datapath: accept, shift one bit per cycle, then publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            count  <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        borrow <= 1'b0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    diff   <= {d, diff[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= borrow_next;
                    count  <= count + CW'(1);
                    if (last_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bout  <= borrow_next;
                        ovf   <= (a_msb ^ b_msb) & (d ^ a_msb);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
